// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared op codes, state codes and op context for the mul/div unit
// Purpose: constants and types imported by the mul/div sequencer, its step datapath and interface.
// Ports: none (package).
package muldiv_sequencer_pkg;

   // Operation encoding presented on operation[2:0]; codes 6 and 7 are no-ops.
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   // Sequencer state codes.
   localparam logic [1:0] MDS_IDLE = 2'd0;
   localparam logic [1:0] MDS_RUN  = 2'd1;
   localparam logic [1:0] MDS_FIX  = 2'd2;

   // What the FIX state needs to know about the op that was issued.
   typedef struct packed {
      logic is_div;      // restoring divide rather than shift-add multiply
      logic neg_result;  // product / quotient must be negated
      logic neg_rem;     // remainder must be negated (dividend was negative)
   } md_ctx_t;

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - issue/result bundle between control unit and mul/div sequencer
// Purpose: groups the op issue, flush, read-stall and HI/LO result signals.
// Ports (master = control unit side drives): start, operation, operandA, operandB, cancel,
//   readRequest; (slave = sequencer drives): busy, shouldStall, done, hi, lo.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       operation;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic             cancel;
   logic             readRequest;
   logic             busy;
   logic             shouldStall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, operation, operandA, operandB, cancel, readRequest,
      input  busy, shouldStall, done, hi, lo
   );

   modport slave (
      input  start, operation, operandA, operandB, cancel, readRequest,
      output busy, shouldStall, done, hi, lo
   );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// rtl/muldiv_sequencer_step.sv - one combinational shift-add or restoring-divide iteration
// Purpose: advances the 2*WIDTH accumulator by one bit.
// Ports: is_divide (select divide step), acc_in (accumulator {upper, lower}),
//   operand (multiplicand or divisor magnitude), acc_out (accumulator after this step).
module muldiv_sequencer_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_divide,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;

   always_comb begin
      // Multiply: acc = {partial product, remaining multiplier bits}; add on LSB, shift right.
      sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
            + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      // Divide: acc = {remainder, remaining dividend bits}; the shifted remainder needs
      // WIDTH+1 bits, so the borrow shows up in trial[WIDTH].
      trial = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
      if (is_divide) begin
         if (!trial[WIDTH]) acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
         else               acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative multiply/divide unit owning HI/LO
// Purpose: runs MULT/MULTU/DIV/DIVU one bit per cycle (IDLE -> RUN x WIDTH -> FIX -> IDLE),
//   writes MTHI/MTLO immediately, and raises shouldStall while busy.
// Ports: clock, reset_n (async active-low), md (slave side of muldiv_sequencer_if:
//   start/operation/operandA/operandB/cancel/readRequest in; busy/shouldStall/done/hi/lo out).
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   muldiv_sequencer_if.slave     md
);
   localparam int              CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]   COUNT_LAST = CW'(WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   md_ctx_t            ctx_q, ctx_d;
   logic               done_q, done_d;

   logic               a_neg, b_neg, op_is_div;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] product;

   muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
      .is_divide (ctx_q.is_div),
      .acc_in    (acc_q),
      .operand   (opnd_q),
      .acc_out   (acc_step)
   );

   always_comb begin
      a_neg     = is_signed_op(md.operation) & md.operandA[WIDTH-1];
      b_neg     = is_signed_op(md.operation) & md.operandB[WIDTH-1];
      abs_a     = a_neg ? -md.operandA : md.operandA;
      abs_b     = b_neg ? -md.operandB : md.operandB;
      op_is_div = (md.operation == MD_DIV) || (md.operation == MD_DIVU);
      product   = ctx_q.neg_result ? -acc_q : acc_q;

      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ctx_d   = ctx_q;
      done_d  = 1'b0;

      case (state_q)
         MDS_IDLE: begin
            if (md.start) begin
               case (md.operation)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     ctx_d.is_div     = op_is_div;
                     ctx_d.neg_result = a_neg ^ b_neg;
                     ctx_d.neg_rem    = a_neg;
                     // Divide shifts the dividend through acc and subtracts the divisor;
                     // multiply shifts the multiplier through acc and adds the multiplicand.
                     opnd_d  = op_is_div ? abs_b : abs_a;
                     acc_d   = {{WIDTH{1'b0}}, (op_is_div ? abs_a : abs_b)};
                     count_d = COUNT_LAST;
                     state_d = MDS_RUN;
                  end
                  MD_MTHI: hi_d = md.operandA;
                  MD_MTLO: lo_d = md.operandA;
                  default: ;
               endcase
            end
         end
         MDS_RUN: begin
            acc_d = acc_step;
            if (count_q == '0) state_d = MDS_FIX;
            else               count_d = count_q - 1'b1;
         end
         MDS_FIX: begin
            if (ctx_q.is_div) begin
               lo_d = ctx_q.neg_result ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = ctx_q.neg_rem ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end else begin
               {hi_d, lo_d} = product;
            end
            done_d  = 1'b1;
            state_d = MDS_IDLE;
         end
         default: state_d = MDS_IDLE;
      endcase

      // A flush discards whatever this cycle would have done, including a same-cycle start.
      if (md.cancel) begin
         state_d = MDS_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MDS_IDLE;
         count_q <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ctx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ctx_q   <= ctx_d;
         done_q  <= done_d;
      end
   end

   assign md.busy        = (state_q != MDS_IDLE);
   assign md.shouldStall = (md.start | md.readRequest) & md.busy;
   assign md.done        = done_q;
   assign md.hi          = hi_q;
   assign md.lo          = lo_q;
endmodule
